cons_blk_acc: RTL
=================

Name: cons_blk_acc

Overview:
- Parametrised successor to the single-register consumer accumulator.
- Accepts producer words over a valid/ready handshake into a small input FIFO and accumulates them in blocks of BLOCK_LEN words.
- Presents each block sum on a valid/ready output port, with wrap or saturate overflow handling and a sticky overflow flag.
- Sits between a producer and any downstream sink that needs per-block sums.

Parameters:
DATA_W, 8, input word width
SUM_W, 16, accumulator and result width (SUM_W >= DATA_W)
DEPTH, 4, input FIFO entries (power of 2, >= 2)
BLOCK_LEN, 4, words per block (>= 1)
SAT, 0, 0 = wrap modulo 2^SUM_W, 1 = saturate at 2^SUM_W-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
in_val  in  1  producer word valid
in_rdy  out  1  FIFO can accept a word
in_data  in  DATA_W  producer word, unsigned
clr  in  1  synchronous soft clear
out_val  out  1  block result valid
out_rdy  in  1  sink accepts result
out_sum  out  SUM_W  block sum
out_ovf  out  1  overflow occurred within this block
sum  out  SUM_W  running partial sum of current block
level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: one clock, synchronous, active-high; rst has priority over everything.
  - On rst=1 at an edge: FIFO empty, level=0, sum=0, block count=0, internal ovf=0, out_val=0, out_sum=0, out_ovf=0, state=ACC.
- in_rdy = !full && !clr && !rst (combinational).
  - Push occurs when in_val && in_rdy at an edge.
  - in_val while in_rdy=0 is ignored; the word is not stored and the producer must hold it.
  - No pass-through: a full FIFO refuses a push even if a pop happens in the same cycle.
- Simultaneous push and pop in one cycle: level unchanged, order preserved. Pointers wrap modulo DEPTH.
- State ACC:
  - If FIFO non-empty, pop one word per cycle.
  - Operand is the word zero-extended to SUM_W+1 bits and added to sum.
  - Carry out, SAT=0: sum takes the low SUM_W bits; ovf is set.
  - Carry out, SAT=1: sum = 2^SUM_W-1; ovf is set.
  - Once saturated, further adds stay at max.
  - On the pop that completes the block (count = BLOCK_LEN-1):
    - out_sum <= final sum, out_ovf <= final ovf, out_val <= 1.
    - sum, count and ovf clear to 0.
    - state <= HOLD.
- State HOLD:
  - No pops; the FIFO keeps filling up to DEPTH.
  - out_val, out_sum and out_ovf are held stable until out_val && out_rdy at an edge.
  - On that edge: out_val <= 0, state <= ACC. The next pop can occur in the following cycle.
  - out_rdy is ignored while out_val=0.
- Latency:
  - A word pushed at edge k is popped and added at edge k+1 at the earliest.
  - A block result is visible right after the edge of its last pop.
  - Throughput is BLOCK_LEN+1 cycles per block with continuous input and out_rdy=1.
- clr=1 with rst=0:
  - At the edge: FIFO flushed, level=0, sum=0, count=0, ovf=0.
  - Any pending out_val is dropped (out_val=0, out_sum and out_ovf cleared). state=ACC.
  - No push occurs that cycle.
- Reset or clr mid-block or in HOLD: all partial data is discarded; no result is emitted for that block.
- BLOCK_LEN=1: every pop produces a result; the block returns to ACC after the handshake.

Test Plan:
- Reset: rst=1 for 2 cycles with in_val=1 -> all outputs 0, level=0. After release, in_rdy=1 and the first push occurs the next edge.
- Basic block (DATA_W=8, SUM_W=9, BLOCK_LEN=4, DEPTH=4, out_rdy=1): push 1,2,3,4 back-to-back -> out_val high for exactly one cycle, out_sum=10, out_ovf=0. sum reads 1, 3, 6 after successive pops, then 0.
- Overflow: push 255 four times. SAT=0 -> out_sum=508, out_ovf=1. SAT=1 -> out_sum=511, out_ovf=1. Next block 1,1,1,1 -> out_sum=4, out_ovf=0.
- Backpressure: out_rdy=0, push 1..8 continuously.
  - First block completes with out_sum=10 and is held.
  - FIFO fills with 5,6,7,8: level=4, in_rdy=0, no loss.
  - Raise out_rdy -> second block out_sum=26.
- Clear mid-block: push 5,6, then clr=1 for one cycle with in_val=1 -> sum=0, level=0, no push that cycle. Then push 1,1,1,1 -> out_sum=4.
- Reset in HOLD: complete a block with out_rdy=0, then assert rst -> out_val=0, out_sum=0 after the edge. Pending FIFO words are discarded; the next block's sum counts only newly pushed words.

Source files
------------

// File: rtl/cons_blk_acc.sv
// cons_blk_acc: block accumulator behind a small input FIFO.
//
// Producer words enter a DEPTH-entry FIFO. The accumulator takes one word
// per cycle and adds it to a running sum. After every BLOCK_LEN words it
// presents the block sum on the output port and waits for the sink to
// accept it. Overflow either wraps modulo 2^SUM_W (SAT=0) or saturates at
// 2^SUM_W-1 (SAT=1). In both modes a sticky flag records whether any add in
// the block carried out.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
//   - valid must not depend on ready.
//   - Once raised, out_val and its payload stay stable until the transfer.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   in_val/in_rdy/in_data producer port (in_rdy is combinational)
//   clr                   synchronous soft clear: flush FIFO, drop the
//                         partial block and any pending result
//   out_val/out_rdy       result port
//   out_sum/out_ovf       block sum and its overflow flag
//   sum                   running partial sum of the current block
//   level                 FIFO occupancy
module cons_blk_acc #(
    parameter int DATA_W    = 8,
    parameter int SUM_W     = 16,
    parameter int DEPTH     = 4,
    parameter int BLOCK_LEN = 4,
    parameter int SAT       = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_val,
    output logic                     in_rdy,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     clr,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [SUM_W-1:0]         out_sum,
    output logic                     out_ovf,
    output logic [SUM_W-1:0]         sum,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    // A one-word block still needs a legal (1-bit) counter.
    localparam int CW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BLOCK_LEN - 1);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              ovf;

    logic              full, empty, push, pop, blk_done, out_hs;
    logic [SUM_W:0]    add_res;
    logic              carry;
    logic [SUM_W-1:0]  sum_next;
    logic              ovf_next;

    // Flow control and datapath arithmetic.
    always_comb begin
        full     = (level == FULL_LVL);
        empty    = (level == '0);
        // No pass-through: a full FIFO refuses even when a pop happens.
        in_rdy   = !full && !clr && !rst;
        push     = in_val && in_rdy;
        pop      = (state_q == ACC) && !empty;
        out_hs   = out_val && out_rdy;

        // One extra bit catches the carry out of the SUM_W-bit add.
        add_res  = {1'b0, sum} + {{(SUM_W + 1 - DATA_W){1'b0}}, mem[rd_ptr]};
        carry    = add_res[SUM_W];
        sum_next = add_res[SUM_W-1:0];
        if (carry && (SAT != 0)) begin
            sum_next = '1;
        end
        ovf_next = ovf || carry;
        blk_done = pop && (count == LAST_CNT);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (blk_done) state_d = HOLD;
            HOLD:    if (out_hs)   state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO storage has no reset. The pointers and the level decide which
    // entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            // Reset and clear discard the same state. Reset wins only in the
            // sense that it also forces in_rdy low.
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            sum     <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            out_val <= 1'b0;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase

            if (blk_done) begin
                out_val <= 1'b1;
                out_sum <= sum_next;
                out_ovf <= ovf_next;
                sum     <= '0;
                count   <= '0;
                ovf     <= 1'b0;
            end else if (pop) begin
                sum     <= sum_next;
                count   <= count + CW'(1);
                ovf     <= ovf_next;
            end else if (out_hs) begin
                out_val <= 1'b0;
            end
        end
    end

endmodule
